// File: rtl/cpu16_bus_pkg.sv
// Shared constants for the CPU16 bus responder: word widths, I/O offsets and
// keyboard status bit positions.
package cpu16_bus_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CODE_W = 8;

  localparam logic [7:0] KBD_DATA = 8'h00;
  localparam logic [7:0] KBD_STAT = 8'h01;

  localparam int unsigned STAT_OVF = 15;
  localparam int unsigned STAT_NE  = 14;

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO: circular buffer with wrapping pointers and a count.
// Optional sticky overflow flag when CPU16_KBD_OVERFLOW_EN is defined.
module kbd_fifo
  import cpu16_bus_pkg::*;
#(
  parameter int unsigned KBD_DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [CODE_W-1:0]         data,
  output logic [CODE_W-1:0]         head,
  output logic [KBD_DEPTH_LOG2:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow
);

  localparam int unsigned DEPTH = 2 ** KBD_DEPTH_LOG2;
  localparam int unsigned CNT_W = KBD_DEPTH_LOG2 + 1;

  logic [CODE_W-1:0]         mem [DEPTH];
  logic [KBD_DEPTH_LOG2-1:0] rd_ptr;
  logic [KBD_DEPTH_LOG2-1:0] wr_ptr;
  logic                      do_pop;
  logic                      do_push;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Pop on empty is ignored; a pop frees a slot so push-while-full can land.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign head = empty ? '0 : mem[rd_ptr];

  // Pointer and count bookkeeping; flush empties the queue at this edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + KBD_DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + KBD_DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= data;
  end

`ifdef CPU16_KBD_OVERFLOW_EN
  logic ovf_q;

  // Sticky flag: a scancode arrived while full with no pop to make room.
  always_ff @(posedge clk) begin
    if (reset || flush)                    ovf_q <= 1'b0;
    else if (push && full && !do_pop)      ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/cpu16_bus_responder.sv
// CPU16 bus responder: RAM plus keyboard I/O page, registered read data with
// one-cycle latency, keystrobe edge-detected pop of the scancode FIFO.
// Build option CPU16_KBD_OVERFLOW_EN: never stall the keyboard source and
// record dropped scancodes in a sticky overflow status bit.
module cpu16_bus_responder
  import cpu16_bus_pkg::*;
#(
  parameter int unsigned RAM_AW         = 12,
  parameter int unsigned KBD_DEPTH_LOG2 = 3,
  parameter logic [7:0]  IO_PAGE        = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] data_out,
  input  logic              write,
  output logic [WORD_W-1:0] data_in,
  output logic [CODE_W-1:0] keycode,
  input  logic              keystrobe,
  input  logic [CODE_W-1:0] kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ready
);

  localparam int unsigned RAM_WORDS = 2 ** RAM_AW;

  logic [WORD_W-1:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0]       ram_idx;
  logic                    io_sel;
  logic [7:0]              offset;
  logic                    keystrobe_q;
  logic                    pop_req;
  logic                    flush;
  logic                    push;
  logic [KBD_DEPTH_LOG2:0] count;
  logic                    full;
  logic                    empty;
  logic                    overflow;
  logic [WORD_W-1:0]       stat;
  logic [WORD_W-1:0]       rd_data;

  assign io_sel  = (address[15:8] == IO_PAGE);
  assign offset  = address[7:0];
  assign ram_idx = address[RAM_AW-1:0];

  assign pop_req = keystrobe && !keystrobe_q;
  assign flush   = write && io_sel && (offset == KBD_STAT);

`ifdef CPU16_KBD_OVERFLOW_EN
  assign kbd_ready = 1'b1;
`else
  assign kbd_ready = !full;
`endif
  assign push = kbd_valid && kbd_ready;

  kbd_fifo #(
    .KBD_DEPTH_LOG2(KBD_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop_req),
    .flush    (flush),
    .data     (kbd_data),
    .head     (keycode),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // Keyboard status word: overflow, not-empty and the entry count.
  always_comb begin
    stat                   = '0;
    stat[STAT_OVF]         = overflow;
    stat[STAT_NE]          = !empty;
    stat[KBD_DEPTH_LOG2:0] = count;
  end

  // Read mux over RAM and the I/O page; unmapped offsets read as zero.
  always_comb begin
    rd_data = '0;
    if (!io_sel) begin
      rd_data = ram[ram_idx];
    end else begin
      case (offset)
        KBD_DATA: rd_data = WORD_W'(keycode);
        KBD_STAT: rd_data = stat;
        default:  rd_data = '0;
      endcase
    end
  end

  // Registered read data and keystrobe history.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_in     <= '0;
      keystrobe_q <= 1'b0;
    end else begin
      data_in     <= rd_data;
      keystrobe_q <= keystrobe;
    end
  end

  // RAM write port; read-first because the read register samples old data.
  always_ff @(posedge clk) begin
    if (!reset && write && !io_sel) ram[ram_idx] <= data_out;
  end

endmodule

// File: tb/tb_cpu16_bus_responder.sv
// Self-checking bench for cpu16_bus_responder with a queue-based reference model.
module tb_cpu16_bus_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, write, keystrobe, kbd_valid, kbd_ready;
  logic [15:0] address, data_out, data_in;
  logic [7:0]  kbd_data, keycode;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] m_ram   [4096];
  bit          m_known [4096];
  logic [7:0]  m_q[$];
  bit          m_ovf;
  bit          m_ksq;
  logic [15:0] m_din;
  bit          m_din_known;

  always #5 clk = ~clk;

  cpu16_bus_responder dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data_out  (data_out),
    .write     (write),
    .data_in   (data_in),
    .keycode   (keycode),
    .keystrobe (keystrobe),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_ready (kbd_ready)
  );

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [15:0] v;
    v = 16'h0000;
    if (a[15:8] != 8'hFF) v = m_ram[a[11:0]];
    else if (a[7:0] == 8'h00) v = (m_q.size() != 0) ? {8'h00, m_q[0]} : 16'h0000;
    else if (a[7:0] == 8'h01) begin
      v[15]  = m_ovf;
      v[14]  = (m_q.size() != 0);
      v[3:0] = 4'(m_q.size());
    end
    return v;
  endfunction

  function automatic bit m_ready();
`ifdef CPU16_KBD_OVERFLOW_EN
    return 1'b1;
`else
    return m_q.size() < DEPTH;
`endif
  endfunction

  function automatic logic [7:0] m_head();
    return (m_q.size() != 0) ? m_q[0] : 8'h00;
  endfunction

  // Drive one cycle, advance the model, sample #1 after the edge.
  task automatic cyc(input bit rst, input logic [15:0] a, input logic [15:0] d,
                     input bit w, input bit ks, input logic [7:0] kd, input bit kv);
    bit popreq, popped, ready0, full0;
    reset = rst; address = a; data_out = d; write = w;
    keystrobe = ks; kbd_data = kd; kbd_valid = kv;
    if (rst) begin
      m_q.delete(); m_ovf = 0; m_ksq = 0; m_din = 16'h0; m_din_known = 1;
    end else begin
      m_din       = m_read(a);
      m_din_known = (a[15:8] == 8'hFF) || m_known[a[11:0]];
      popreq      = ks && !m_ksq;
      m_ksq       = ks;
      ready0      = m_ready();
      full0       = (m_q.size() == DEPTH);
      if (w && a[15:8] != 8'hFF) begin
        m_ram[a[11:0]]   = d;
        m_known[a[11:0]] = 1;
      end
      if (w && a == 16'hFF01) begin
        m_q.delete(); m_ovf = 0;
      end else begin
        popped = 0;
        if (popreq && m_q.size() != 0) begin
          void'(m_q.pop_front());
          popped = 1;
        end
        if (kv && ready0) begin
          if (!full0 || popped) m_q.push_back(kd);
          else m_ovf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ks);
    cyc(0, 16'hFF10, 16'h0, 0, ks, 8'h00, 0);
  endtask

  task automatic read_stat(input bit ks);
    cyc(0, 16'hFF01, 16'h0, 0, ks, 8'h00, 0);
  endtask

  task automatic test_reset();
    cyc(1, 16'h0000, 16'h0, 0, 0, 8'h00, 0);
    cyc(1, 16'h0000, 16'h0, 0, 0, 8'h00, 0);
    n_cmp++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL reset_data_in: got %h want 0000", data_in); end
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL reset_keycode: got %h want 00", keycode); end
    n_cmp++; if (kbd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_kbd_ready: got %b want 1", kbd_ready); end
    read_stat(0);
    n_cmp++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL reset_stat: got %h want 0000", data_in); end
  endtask

  task automatic test_ram_rw();
    cyc(0, 16'h0123, 16'h1111, 1, 0, 8'h00, 0);
    cyc(0, 16'h0123, 16'hBEEF, 1, 0, 8'h00, 0);
    n_cmp++; if (data_in !== 16'h1111) begin n_bad++; $display("FAIL ram_read_first: got %h want 1111", data_in); end
    cyc(0, 16'h0123, 16'h0000, 0, 0, 8'h00, 0);
    n_cmp++; if (data_in !== 16'hBEEF) begin n_bad++; $display("FAIL ram_read: got %h want beef", data_in); end
    cyc(0, 16'h1123, 16'h0000, 0, 0, 8'h00, 0);
    n_cmp++; if (data_in !== 16'hBEEF) begin n_bad++; $display("FAIL ram_alias: got %h want beef", data_in); end
    cyc(0, 16'hFF05, 16'h5A5A, 1, 0, 8'h00, 0);
    n_cmp++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL io_unmapped: got %h want 0000", data_in); end
  endtask

  task automatic test_kbd_queue();
    cyc(0, 16'hFF10, 16'h0, 0, 0, 8'h41, 1);
    n_cmp++; if (keycode !== 8'h41) begin n_bad++; $display("FAIL q_first_push: got %h want 41", keycode); end
    cyc(0, 16'hFF10, 16'h0, 0, 0, 8'h42, 1);
    read_stat(0);
    n_cmp++; if (data_in !== 16'h4002) begin n_bad++; $display("FAIL q_stat2: got %h want 4002", data_in); end
    n_cmp++; if (keycode !== 8'h41) begin n_bad++; $display("FAIL q_head: got %h want 41", keycode); end
    cyc(0, 16'hFF00, 16'h0, 0, 0, 8'h00, 0);
    n_cmp++; if (data_in !== 16'h0041) begin n_bad++; $display("FAIL q_kbd_data: got %h want 0041", data_in); end
    idle(1);
    n_cmp++; if (keycode !== 8'h42) begin n_bad++; $display("FAIL q_pop: got %h want 42", keycode); end
    idle(1);
    idle(1);
    read_stat(0);
    n_cmp++; if (data_in !== 16'h4001) begin n_bad++; $display("FAIL q_single_pop: got %h want 4001", data_in); end
    n_cmp++; if (keycode !== 8'h42) begin n_bad++; $display("FAIL q_head_held: got %h want 42", keycode); end
    idle(1);
    idle(0);
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL q_drain: got %h want 00", keycode); end
  endtask

  task automatic test_empty();
    idle(1);
    read_stat(0);
    n_cmp++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL empty_pop_stat: got %h want 0000", data_in); end
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL empty_pop_key: got %h want 00", keycode); end
    cyc(0, 16'hFF10, 16'h0, 0, 1, 8'hA0, 1);
    n_cmp++; if (keycode !== 8'hA0) begin n_bad++; $display("FAIL empty_push_pop_key: got %h want a0", keycode); end
    read_stat(0);
    n_cmp++; if (data_in !== 16'h4001) begin n_bad++; $display("FAIL empty_push_pop_stat: got %h want 4001", data_in); end
    idle(1);
    idle(0);
  endtask

`ifndef CPU16_KBD_OVERFLOW_EN
  task automatic test_full();
    for (int i = 1; i <= 8; i++) cyc(0, 16'hFF10, 16'h0, 0, 0, 8'(i), 1);
    n_cmp++; if (kbd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", kbd_ready); end
    cyc(0, 16'hFF01, 16'h0, 0, 0, 8'h09, 1);
    n_cmp++; if (data_in !== 16'h4008) begin n_bad++; $display("FAIL full_stat: got %h want 4008", data_in); end
    n_cmp++; if (keycode !== 8'h01) begin n_bad++; $display("FAIL full_head: got %h want 01", keycode); end
    cyc(0, 16'hFF10, 16'h0, 0, 1, 8'h09, 1);
    n_cmp++; if (keycode !== 8'h02) begin n_bad++; $display("FAIL full_pop_head: got %h want 02", keycode); end
    n_cmp++; if (kbd_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_ready: got %b want 1", kbd_ready); end
    cyc(0, 16'hFF10, 16'h0, 0, 0, 8'h09, 1);
    n_cmp++; if (kbd_ready !== 1'b0) begin n_bad++; $display("FAIL full_refill_ready: got %b want 0", kbd_ready); end
    for (int j = 0; j < 7; j++) begin idle(1); idle(0); end
    n_cmp++; if (keycode !== 8'h09) begin n_bad++; $display("FAIL full_tail: got %h want 09", keycode); end
    cyc(0, 16'hFF01, 16'h1234, 1, 0, 8'h00, 0);
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL full_flush: got %h want 00", keycode); end
  endtask
`else
  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) cyc(0, 16'hFF10, 16'h0, 0, 0, 8'(i), 1);
    n_cmp++; if (kbd_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready: got %b want 1", kbd_ready); end
    read_stat(0);
    n_cmp++; if (data_in !== 16'hC008) begin n_bad++; $display("FAIL ovf_stat: got %h want c008", data_in); end
    for (int j = 0; j < 7; j++) begin idle(1); idle(0); end
    n_cmp++; if (keycode !== 8'h08) begin n_bad++; $display("FAIL ovf_tail: got %h want 08", keycode); end
    read_stat(0);
    n_cmp++; if (data_in !== 16'hC001) begin n_bad++; $display("FAIL ovf_sticky: got %h want c001", data_in); end
    cyc(0, 16'hFF01, 16'h1234, 1, 0, 8'h00, 0);
    read_stat(0);
    n_cmp++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL ovf_clear: got %h want 0000", data_in); end
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL ovf_flush_key: got %h want 00", keycode); end
  endtask
`endif

  task automatic test_reset_mid();
    cyc(0, 16'h0200, 16'h5555, 1, 0, 8'h00, 0);
    cyc(0, 16'hFF10, 16'h0, 0, 0, 8'h11, 1);
    cyc(0, 16'hFF10, 16'h0, 0, 0, 8'h22, 1);
    cyc(0, 16'hFF10, 16'h0, 0, 0, 8'h33, 1);
    cyc(1, 16'h0200, 16'hAAAA, 1, 1, 8'h77, 1);
    n_cmp++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL rstmid_data_in: got %h want 0000", data_in); end
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL rstmid_keycode: got %h want 00", keycode); end
    n_cmp++; if (kbd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", kbd_ready); end
    cyc(0, 16'h0200, 16'h0, 0, 0, 8'h00, 0);
    n_cmp++; if (data_in !== 16'h5555) begin n_bad++; $display("FAIL rstmid_ram: got %h want 5555", data_in); end
    read_stat(0);
    n_cmp++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL rstmid_stat: got %h want 0000", data_in); end
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    bit w, ks, kv;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        a = {4'($urandom_range(0, 14)), 4'h0, 4'h4, 4'($urandom)};
        w = ($urandom_range(0, 99) < 40);
      end else if (r < 90) begin
        a = {8'hFF, 8'($urandom_range(0, 1))};
        w = ($urandom_range(0, 99) < 5);
      end else begin
        a = {8'hFF, 8'($urandom_range(2, 255))};
        w = ($urandom_range(0, 99) < 30);
      end
      d  = 16'($urandom);
      ks = ($urandom_range(0, 99) < 40);
      kv = ($urandom_range(0, 99) < 60);
      cyc(0, a, d, w, ks, 8'($urandom), kv);
      if (m_din_known) begin
        n_cmp++; if (data_in !== m_din) begin n_bad++; $display("FAIL rnd_data_in[%0d]: got %h want %h", n, data_in, m_din); end
      end
      n_cmp++; if (keycode !== m_head()) begin n_bad++; $display("FAIL rnd_keycode[%0d]: got %h want %h", n, keycode, m_head()); end
      n_cmp++; if (kbd_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, kbd_ready, m_ready()); end
    end
  endtask

  initial begin
    reset = 1; address = 16'h0; data_out = 16'h0; write = 0;
    keystrobe = 0; kbd_data = 8'h00; kbd_valid = 0;
    m_ovf = 0; m_ksq = 0; m_din = 16'h0; m_din_known = 0;
    test_reset();
    test_ram_rw();
    test_kbd_queue();
    test_empty();
`ifndef CPU16_KBD_OVERFLOW_EN
    test_full();
`else
    test_overflow();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu16_bus_responder.md
Name: cpu16_bus_responder

Overview:
- Memory/peripheral responder on the CPU16 bus: serves the core's address/data_out/write requests and returns read data on data_in, timed for a CPU built with RAM_WAIT=1.
- Also owns the keyboard side of the keycode/keystrobe handshake: it buffers scancodes in a FIFO, presents the head on keycode, and pops the head on each keystrobe rising edge.
- Sits between the CPU16 core and the board keyboard source; it is the only RAM and I/O decoder in the system.

Parameters:
- RAM_AW, 12, RAM word-address width; RAM holds 2^RAM_AW 16-bit words.
- KBD_DEPTH_LOG2, 3, log2 of keyboard FIFO depth (default 8 entries).
- IO_PAGE, 8'hFF, address[15:8] value that selects the I/O page.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- address  in  16  word address from CPU
- data_out  in  16  CPU write data
- write  in  1  CPU write strobe; one write per sampled-high cycle
- data_in  out  16  registered read data to CPU
- keycode  out  8  FIFO head; 8'h00 when FIFO is empty
- keystrobe  in  1  CPU acknowledge; the rising edge pops the FIFO
- kbd_data  in  8  scancode from keyboard source
- kbd_valid  in  1  scancode present
- kbd_ready  out  1  FIFO can accept; a push occurs when kbd_valid && kbd_ready

Behaviour:
- Reset: data_in=0, FIFO emptied (keycode=0, count=0), kbd_ready=1, keystrobe edge register=0, overflow flag=0. RAM contents are not cleared. Writes and pushes sampled during reset are ignored.
- Decode:
  - address[15:8]==IO_PAGE selects I/O.
  - All other addresses select RAM, indexed by address[RAM_AW-1:0]; higher bits alias.
- Read latency:
  - data_in is registered every cycle from the address sampled at that edge.
  - Address presented at edge t gives data valid after edge t+1, which meets the CPU's SELECT→DECODE_WAIT→DECODE timing.
  - data_in updates every cycle, whether or not write is high.
- RAM write: at an edge with write=1, data_out is stored at the RAM index. A read of the same address in the same cycle returns the old data (read-first).
- I/O map, by offset address[7:0]:
  - 0x00 KBD_DATA read: {8'h00, head}, or 0 if empty. No pop. Writes ignored.
  - 0x01 KBD_STAT read:
    - bit15 = overflow flag (0 when the optional feature is absent)
    - bit14 = not-empty
    - bits[KBD_DEPTH_LOG2:0] = count
    - other bits 0.
  - 0x01 KBD_STAT write (any data): flush the FIFO and clear overflow. Takes effect at that edge; a push in the same cycle is dropped.
  - Other offsets: reads return 0; writes are ignored.
- keystrobe handshake:
  - Register keystrobe. A pop request is keystrobe && !keystrobe_q.
  - A level held high pops only once.
  - A pop when empty is ignored.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count of width KBD_DEPTH_LOG2+1.
  - keycode = mem[rd_ptr] when count!=0, else 0. It updates the cycle after a pop or after the first push.
  - Simultaneous push and pop on a non-empty FIFO: count is unchanged, both pointers advance.
  - Push and pop on an empty FIFO: the pop is ignored and the push is taken.
  - Full: count==2^KBD_DEPTH_LOG2, kbd_ready=0, no push.
- kbd_ready is combinational from count (and the optional feature).

Optional Feature:
- Macro CPU16_KBD_OVERFLOW_EN.
- Defined:
  - kbd_ready is tied to 1 (the source is never stalled).
  - kbd_valid while full drops the scancode and sets the sticky overflow flag (KBD_STAT bit15).
  - The flag is cleared only by reset or a KBD_STAT write.
  - Simultaneous pop and push while full is accepted (no overflow).
- Undefined:
  - kbd_ready = !full.
  - No overflow register; bit15 reads 0.

Decomposition:
- Package cpu16_bus_pkg:
  - I/O offsets KBD_DATA=8'h00, KBD_STAT=8'h01
  - status bit positions STAT_OVF=15, STAT_NE=14
  - WORD_W=16
- Sub-module kbd_fifo (parameter KBD_DEPTH_LOG2):
  - ports: push, pop, flush, data, head, count, full, empty
  - owns overflow logic under the macro.
- The top level does decode, the RAM array, the read register and keystrobe edge detection.

Test Plan:
- RAM write/read:
  - Stimulus: write 16'hBEEF to 0x0123, then address 0x0123 with write=0.
  - Expect data_in==16'hBEEF after edge t+1, and not at edge t.
  - Then read 0x1123: also 16'hBEEF (alias, RAM_AW=12).
- Keyboard queue:
  - Stimulus: push 8'h41, 8'h42.
  - Expect keycode==8'h41 and KBD_STAT read==16'h4002.
  - Then raise keystrobe and hold it high for 3 cycles: keycode==8'h42 and count==1, exactly one pop.
- Empty behaviour:
  - Stimulus: keystrobe pulse on an empty FIFO.
  - Expect keycode==0 and count==0.
  - Then, in one cycle, push 8'hA0 together with a keystrobe rising edge: keycode==8'hA0 and count==1.
- Full/backpressure (macro undefined):
  - Stimulus: push 9 codes 8'h01..8'h09 with kbd_valid held high.
  - Expect kbd_ready==0 after the 8th; 8'h09 is not accepted until a pop.
  - After one pop: head==8'h02 and 8'h09 enters.
- Overflow (macro defined):
  - Stimulus: push 9 codes.
  - Expect KBD_STAT==16'hC008 and 8'h09 lost.
  - Write 0xFF01: KBD_STAT==0 and keycode==0.
- Reset mid-operation:
  - Stimulus: assert reset during a RAM write cycle with 3 codes queued.
  - Expect data_in==0, keycode==0, kbd_ready==1, and the target RAM word unchanged.
